// File: rtl/ccff_chain_loader.sv
// Streams a word-wide bitstream serially into a configuration flip-flop chain,
// optionally followed by a readback pass that compares the chain tail against a re-sent stream.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              fab_clk_en,
  output logic              busy,
  output logic              cfg_done,
  output logic              err,
  output logic [15:0]       mismatch_cnt
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t            state_q;
  logic              verify_q;
  logic [WORD_W-1:0] buf_q;
  logic              buf_valid_q;
  logic [IDX_W-1:0]  buf_idx_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              busy_q;
  logic              cfg_done_q;
  logic              err_q;
  logic [15:0]       mismatch_cnt_q;

  logic active;
  logic shift;
  logic pass_end;
  logic final_end;
  logic word_end;
  logic accept;

  assign active    = (state_q == LOAD) || (state_q == VERIFY);
  assign shift     = active && buf_valid_q;
  assign pass_end  = shift && (bit_cnt_q == LAST_BIT);
  assign final_end = pass_end && ((state_q == VERIFY) || !verify_q);
  // The last bit of a pass also ends the current word, even if upper bits remain unused.
  assign word_end  = shift && ((buf_idx_q == LAST_IDX) || pass_end);
  // A word arriving on the last shift of the final pass would have nowhere to go.
  assign din_ready = active && (!buf_valid_q || (word_end && !final_end));
  assign accept    = din_valid && din_ready;

  assign fab_clk_en   = shift;
  assign ccff_head    = buf_q[0];
  assign busy         = busy_q;
  assign cfg_done     = cfg_done_q;
  assign err          = err_q;
  assign mismatch_cnt = mismatch_cnt_q;

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q        <= IDLE;
      verify_q       <= 1'b0;
      buf_q          <= '0;
      buf_valid_q    <= 1'b0;
      buf_idx_q      <= '0;
      bit_cnt_q      <= '0;
      busy_q         <= 1'b0;
      cfg_done_q     <= 1'b0;
      err_q          <= 1'b0;
      mismatch_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q        <= LOAD;
            verify_q       <= verify_en;
            bit_cnt_q      <= '0;
            busy_q         <= 1'b1;
            cfg_done_q     <= 1'b0;
            err_q          <= 1'b0;
            mismatch_cnt_q <= '0;
          end
        end
        default: begin
          if (shift) begin
            bit_cnt_q <= pass_end ? '0 : bit_cnt_q + CNT_W'(1);
            if ((state_q == VERIFY) && (ccff_tail != buf_q[0])) begin
              err_q <= 1'b1;
              if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_q <= mismatch_cnt_q + 16'd1;
            end
          end
          if (final_end) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            cfg_done_q <= 1'b1;
          end else if (pass_end) begin
            state_q <= VERIFY;
          end
          if (accept) begin
            buf_q       <= din;
            buf_valid_q <= 1'b1;
            buf_idx_q   <= '0;
          end else if (word_end) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
          end else if (shift) begin
            buf_q     <= buf_q >> 1;
            buf_idx_q <= buf_idx_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 16-bit chain instance (loads, verify, stalls, reset)
// and a 12-bit chain instance (partial final word).
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  // 16-flop chain instance
  logic        start_a = 0, ven_a = 0, dv_a = 0;
  logic [7:0]  din_a = 0;
  logic        rdy_a, head_a, tail_a, fen_a, busy_a, done_a, err_a;
  logic [15:0] cnt_a;
  logic [15:0] chain_a = '0;
  int          shifts_a = 0, stall_a = 0;

  // 12-flop chain instance
  logic        start_b = 0, ven_b = 0, dv_b = 0;
  logic [7:0]  din_b = 0;
  logic        rdy_b, head_b, tail_b, fen_b, busy_b, done_b, err_b;
  logic [15:0] cnt_b;
  logic [11:0] chain_b = '0;
  int          shifts_b = 0;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
    .prog_clk(clk), .prog_reset(rst_n), .start(start_a), .verify_en(ven_a),
    .din(din_a), .din_valid(dv_a), .din_ready(rdy_a), .ccff_head(head_a),
    .ccff_tail(tail_a), .fab_clk_en(fen_a), .busy(busy_a), .cfg_done(done_a),
    .err(err_a), .mismatch_cnt(cnt_a));

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .prog_clk(clk), .prog_reset(rst_n), .start(start_b), .verify_en(ven_b),
    .din(din_b), .din_valid(dv_b), .din_ready(rdy_b), .ccff_head(head_b),
    .ccff_tail(tail_b), .fab_clk_en(fen_b), .busy(busy_b), .cfg_done(done_b),
    .err(err_b), .mismatch_cnt(cnt_b));

  assign tail_a = chain_a[15];
  assign tail_b = chain_b[11];

  // Chain models: shift registers clocked by the gated programming clock.
  always @(posedge clk) begin
    if (fen_a) begin
      chain_a  <= {chain_a[14:0], head_a};
      shifts_a <= shifts_a + 1;
    end
    if (busy_a && !fen_a) stall_a <= stall_a + 1;
    if (fen_b) begin
      chain_b  <= {chain_b[10:0], head_b};
      shifts_b <= shifts_b + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: stream bit k lands k places from the tail after a full pass.
  function automatic logic [15:0] model16(input logic [7:0] w0, input logic [7:0] w1);
    logic [15:0] s, r;
    s = {w1, w0};
    for (int k = 0; k < 16; k++) r[15-k] = s[k];
    return r;
  endfunction

  function automatic logic [11:0] model12(input logic [7:0] w0, input logic [7:0] w1);
    logic [15:0] s;
    logic [11:0] r;
    s = {w1, w0};
    for (int k = 0; k < 12; k++) r[11-k] = s[k];
    return r;
  endfunction

  function automatic int popc16(input logic [15:0] v);
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(v[k]);
    return n;
  endfunction

  // gap = number of cycles the loader could take the word but din_valid is held low.
  task automatic send_a(input logic [7:0] w, input int gap);
    int n = 0;
    int t = 0;
    logic ok = 1'b0;
    dv_a = 1'b0;
    while (n < gap && t < 200) begin
      @(negedge clk);
      if (rdy_a) n++;
      t++;
      @(posedge clk); #1;
    end
    din_a = w;
    dv_a  = 1'b1;
    t = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = rdy_a;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) chk("handshake_timeout", 32'(ok), 32'd1);
    dv_a = 1'b0;
  endtask

  task automatic run_a(input string nm, input logic ven, input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] v0, input logic [7:0] v1, input int gap,
                       input logic exp_err, input int exp_cnt, input logic [15:0] exp_chain);
    int s0, t0, pass_n;
    logic ok = 1'b0;
    s0 = shifts_a;
    t0 = stall_a;
    pass_n = ven ? 2 : 1;
    @(posedge clk); #1;
    start_a = 1'b1; ven_a = ven;
    @(posedge clk); #1;
    start_a = 1'b0; ven_a = 1'b0;
    chk({nm, "_busy_start"}, 32'(busy_a), 32'd1);
    chk({nm, "_done_clr"}, 32'(done_a), 32'd0);
    send_a(l0, 0);
    send_a(l1, gap);
    if (ven) begin
      send_a(v0, 0);
      send_a(v1, gap);
    end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = done_a;
    end
    chk({nm, "_done"}, 32'(ok), 32'd1);
    chk({nm, "_chain"}, 32'(chain_a), 32'(exp_chain));
    chk({nm, "_shifts"}, 32'(shifts_a - s0), 32'(16 * pass_n));
    chk({nm, "_stalls"}, 32'(stall_a - t0), 32'(1 + gap * pass_n));
    chk({nm, "_err"}, 32'(err_a), 32'(exp_err));
    chk({nm, "_mcnt"}, 32'(cnt_a), 32'(exp_cnt));
    chk({nm, "_busy_end"}, 32'(busy_a), 32'd0);
    // Extra words offered after completion must not be taken or shifted.
    @(posedge clk); #1;
    din_a = 8'hFF; dv_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({nm, "_rdy_after"}, 32'(rdy_a), 32'd0);
    chk({nm, "_no_extra"}, 32'(shifts_a - s0), 32'(16 * pass_n));
    chk({nm, "_done_hold"}, 32'(done_a), 32'd1);
    @(posedge clk); #1;
    dv_a = 1'b0;
    $display("txn %s ven=%0d load=%02h%02h ver=%02h%02h gap=%0d chain=%04h err=%0d mcnt=%0d",
             nm, ven, l1, l0, v1, v0, gap, chain_a, err_a, cnt_a);
  endtask

  task automatic run_b(input string nm, input logic [7:0] w0, input logic [7:0] w1);
    int s0, idx, t;
    logic acc;
    logic ok = 1'b0;
    s0 = shifts_b;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    din_b = w0; dv_b = 1'b1; idx = 0; t = 0;
    while (idx < 2 && t < 100) begin
      @(negedge clk);
      acc = rdy_b;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        din_b = (idx == 1) ? w1 : 8'hAA;
      end
      t++;
    end
    chk({nm, "_words"}, 32'(idx), 32'd2);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = done_b;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({nm, "_done"}, 32'(done_b), 32'd1);
    chk({nm, "_shifts"}, 32'(shifts_b - s0), 32'd12);
    chk({nm, "_chain"}, 32'(chain_b), 32'(model12(w0, w1)));
    chk({nm, "_rdy_after"}, 32'(rdy_b), 32'd0);
    chk({nm, "_head_after"}, 32'(head_b), 32'd0);
    @(posedge clk); #1;
    dv_b = 1'b0;
    $display("txn %s words=%02h,%02h chain=%03h shifts=%0d", nm, w0, w1, chain_b, shifts_b - s0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_head"}, 32'(head_a), 32'd0);
    chk({nm, "_fen"}, 32'(fen_a), 32'd0);
    chk({nm, "_rdy"}, 32'(rdy_a), 32'd0);
    chk({nm, "_busy"}, 32'(busy_a), 32'd0);
    chk({nm, "_done"}, 32'(done_a), 32'd0);
    chk({nm, "_err"}, 32'(err_a), 32'd0);
    chk({nm, "_mcnt"}, 32'(cnt_a), 32'd0);
  endtask

  typedef struct {
    string       nm;
    logic        ven;
    logic [7:0]  l0, l1, v0, v1;
    int          gap;
    logic        exp_err;
    int          exp_cnt;
    logic [15:0] exp_chain;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"load_a53c",   1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 0, 1'b0, 0,  16'hA53C};
    vecs[1] = '{"verify_ok",   1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0, 1'b0, 0,  16'hA53C};
    vecs[2] = '{"verify_bad",  1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3D, 0, 1'b1, 1,  16'hA5BC};
    vecs[3] = '{"load_gap5",   1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 5, 1'b0, 0,  16'hA53C};
    vecs[4] = '{"verify_all",  1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 2, 1'b1, 16, 16'hFFFF};
    vecs[5] = '{"load_8001",   1'b0, 8'h01, 8'h80, 8'h00, 8'h00, 1, 1'b0, 0,  16'h8001};

    #1 rst_n = 1'b0;
    #2;
    chk_reset_outs("por");
    chk("por_rdy_b", 32'(rdy_b), 32'd0);
    chk("por_done_b", 32'(done_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_a(vecs[i].nm, vecs[i].ven, vecs[i].l0, vecs[i].l1, vecs[i].v0, vecs[i].v1,
            vecs[i].gap, vecs[i].exp_err, vecs[i].exp_cnt, vecs[i].exp_chain);

    // Partial final word on the 12-flop chain.
    run_b("b_ff0f", 8'hFF, 8'h0F);
    run_b("b_5ac3", 8'h5A, 8'hC3);

    // Reset mid-pass after 7 shifts, then a clean reload.
    begin
      int s0, t;
      s0 = shifts_a;
      @(posedge clk); #1;
      start_a = 1'b1; ven_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; ven_a = 1'b0;
      din_a = 8'h5A; dv_a = 1'b1;
      t = 0;
      while (shifts_a - s0 < 7 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      chk("midrst_reach7", 32'(shifts_a - s0), 32'd7);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      dv_a = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_frozen", 32'(shifts_a - s0), 32'd7);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_idle_busy", 32'(busy_a), 32'd0);
      chk("midrst_idle_shifts", 32'(shifts_a - s0), 32'd7);
      $display("txn midpass_reset shifts_before_reset=%0d", shifts_a - s0);
      run_a("after_reset", 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 0, 1'b0, 0, 16'hA53C);
    end

    // Randomized loads/verifies against the arithmetic reference.
    for (int i = 0; i < 16; i++) begin
      logic        ven;
      logic [7:0]  l0, l1, v0, v1;
      int          gap;
      logic [15:0] ld, vf;
      ven = 1'($urandom_range(0, 1));
      l0 = 8'($urandom); l1 = 8'($urandom);
      v0 = l0; v1 = l1;
      if ($urandom_range(0, 2) != 0) v0 = v0 ^ 8'($urandom);
      if ($urandom_range(0, 2) != 0) v1 = v1 ^ 8'($urandom);
      gap = int'($urandom_range(0, 3));
      ld = {l1, l0};
      vf = {v1, v0};
      if (ven)
        run_a($sformatf("rnd%0d", i), ven, l0, l1, v0, v1, gap,
              popc16(ld ^ vf) != 0, popc16(ld ^ vf), model16(v0, v1));
      else
        run_a($sformatf("rnd%0d", i), ven, l0, l1, v0, v1, gap, 1'b0, 0, model16(l0, l1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
